// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // Architectural register index width (x0..x31).
  localparam int REG_W = 5;

  // Largest legal cache-wait timeout; the wait counter is sized to hold it.
  localparam int TIMEOUT_MAX = 255;
  localparam int WAIT_W      = $clog2(TIMEOUT_MAX + 1);

  // Sequencer states. The fourth encoding is unused and recovers to RUN.
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use hazard comparator (ID sources vs EX load).
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  output logic             hazard_o
);

  // A load writing x0 never creates a dependency, so rd==0 is excluded.
  always_comb begin
    hazard_o = ex_mem_read_i && (ex_rd_i != '0) &&
               ((ex_rd_i == rs1_i) || (ex_rd_i == rs2_i));
  end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer: load-use bubbles, branch flush, blocking
//            data-cache handshake with timeout, stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IF_ID_Rs1_i,
  input  logic [REG_W-1:0] IF_ID_Rs2_i,
  input  logic [REG_W-1:0] ID_EX_Rd_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             Branch_i,
  input  logic             MemReq_i,
  input  logic             cache_ack_i,
  output logic             cache_req_o,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             Stall_o,
  output logic             error_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               hazard;
  logic               stall;
  logic               req;

  load_use_detect u_load_use_detect (
    .rs1_i         (IF_ID_Rs1_i),
    .rs2_i         (IF_ID_Rs2_i),
    .ex_rd_i       (ID_EX_Rd_i),
    .ex_mem_read_i (ID_EX_MemRead_i),
    .hazard_o      (hazard)
  );

  // Next-state, wait counter and cache handshake for the MEM-stage access.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall   = 1'b0;
    req     = 1'b0;
    case (state_q)
      ST_RUN: begin
        req = MemReq_i;
        if (MemReq_i && !cache_ack_i) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (cache_ack_i) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          stall = 1'b1;
          if (wait_q == C_TIMEOUT) begin
            state_d = ST_ERR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Output priority: global freeze, then load-use bubble, then branch flush.
  always_comb begin
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    Flush_o       = 1'b0;
    if (stall) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
    end else if (hazard) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      NoOp_o        = 1'b1;
    end else if (Branch_i) begin
      Flush_o = 1'b1;
    end
  end

  // Saturating stall/bubble counter and sticky timeout flag.
  always_comb begin
    cnt_d = cnt_q;
    if ((stall || NoOp_o) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q || (state_d == ST_ERR);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign Stall_o     = stall;
  assign cache_req_o = req && rst_i;
  assign error_o     = err_q;
  assign state_o     = state_q;
  assign stall_cnt_o = cnt_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed, table-driven self-checking bench for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  IF_ID_Rs1_i, IF_ID_Rs2_i, ID_EX_Rd_i;
  logic        ID_EX_MemRead_i, Branch_i, MemReq_i, cache_ack_i;
  logic        cache_req_o, PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o;
  logic        Stall_o, error_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .IF_ID_Rs1_i     (IF_ID_Rs1_i),
    .IF_ID_Rs2_i     (IF_ID_Rs2_i),
    .ID_EX_Rd_i      (ID_EX_Rd_i),
    .ID_EX_MemRead_i (ID_EX_MemRead_i),
    .Branch_i        (Branch_i),
    .MemReq_i        (MemReq_i),
    .cache_ack_i     (cache_ack_i),
    .cache_req_o     (cache_req_o),
    .PCWrite_o       (PCWrite_o),
    .IF_ID_Write_o   (IF_ID_Write_o),
    .NoOp_o          (NoOp_o),
    .Flush_o         (Flush_o),
    .Stall_o         (Stall_o),
    .error_o         (error_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  // Output bundle: {pcw, ifw, noop, flush, stall, req, err, state[1:0]}
  wire [8:0] outs = {PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Stall_o,
                     cache_req_o, error_o, state_o};

  localparam logic [8:0] O_IDLE   = 9'b1_1_0_0_0_0_0_00;
  localparam logic [8:0] O_HAZ    = 9'b0_0_1_0_0_0_0_00;
  localparam logic [8:0] O_BR     = 9'b1_1_0_1_0_0_0_00;
  localparam logic [8:0] O_HIT    = 9'b1_1_0_0_0_1_0_00;
  localparam logic [8:0] O_HIT_BR = 9'b1_1_0_1_0_1_0_00;
  localparam logic [8:0] O_MISS   = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] O_WAIT   = 9'b0_0_0_0_1_1_0_01;
  localparam logic [8:0] O_ACK    = 9'b1_1_0_0_0_1_0_01;
  localparam logic [8:0] O_ERR    = 9'b0_0_0_0_1_0_1_10;
  localparam logic [8:0] O_RSTW   = 9'b0_0_0_0_1_0_0_01;
  localparam logic [8:0] O_RSTR   = 9'b0_0_0_0_1_0_0_00;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, mq, ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mq, input logic ack,
                       input logic rst);
    IF_ID_Rs1_i = rs1; IF_ID_Rs2_i = rs2; ID_EX_Rd_i = rd;
    ID_EX_MemRead_i = mr; Branch_i = br; MemReq_i = mq; cache_ack_i = ack;
    rst_i = rst;
  endtask

  // Check outputs mid-cycle, then advance one edge and update the counter model.
  task automatic cycle(input string name, input logic [8:0] exp);
    @(negedge clk_i);
    check({name, ".outs"}, {23'd0, outs}, {23'd0, exp});
    check({name, ".cnt"}, stall_cnt_o, exp_cnt);
    @(posedge clk_i);
    #1;
    if (!rst_i) exp_cnt = 0;
    else if (exp[6] || exp[4]) exp_cnt++;
  endtask

  initial begin
    vecs[0]  = '{"idle0",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1]  = '{"idle1",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[2]  = '{"idle2",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[3]  = '{"lu_rs2",    5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ};
    vecs[4]  = '{"lu_rd0",    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[5]  = '{"lu_rs1",    5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_HAZ};
    vecs[6]  = '{"no_load",   5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[7]  = '{"br_lu",     5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_HAZ};
    vecs[8]  = '{"br_retry",  5'd3, 5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[9]  = '{"hit",       5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_HIT};
    vecs[10] = '{"ack_idle",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE};
    vecs[11] = '{"hit_br",    5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_HIT_BR};

    // Reset for two edges with idle inputs.
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_cnt = 0;

    // Table: RUN-state priority and hazard detection.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br,
            vecs[i].mq, vecs[i].ack, 1'b1);
      cycle(vecs[i].name, vecs[i].exp);
    end

    // Miss acked three cycles after the request; stall overrides a hazard.
    drive(0, 0, 0, 0, 0, 1, 0, 1'b1);  cycle("miss0", O_MISS);
    drive(5, 0, 5, 1, 1, 0, 0, 1'b1);  cycle("miss1", O_WAIT);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);  cycle("miss2", O_WAIT);
    drive(0, 0, 0, 0, 0, 0, 1, 1'b1);  cycle("miss_ack", O_ACK);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);  cycle("miss_done", O_IDLE);

    // Timeout: four no-ack wait cycles, then ERROR held until reset.
    drive(0, 0, 0, 0, 0, 1, 0, 1'b1);  cycle("to_miss", O_MISS);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);
    for (int k = 1; k <= 4; k++) cycle($sformatf("to_wait%0d", k), O_WAIT);
    cycle("to_err", O_ERR);
    drive(0, 0, 0, 0, 0, 1, 1, 1'b1);  cycle("err_hold", O_ERR);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);  cycle("err_rst", O_ERR);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);  cycle("err_recover", O_IDLE);

    // Reset asserted in the middle of a cache wait.
    drive(0, 0, 0, 0, 0, 1, 0, 1'b1);  cycle("mr_miss", O_MISS);
    drive(0, 0, 0, 0, 0, 1, 0, 1'b1);  cycle("mr_wait", O_WAIT);
    drive(0, 0, 0, 0, 0, 1, 0, 1'b0);  cycle("mr_rst_wait", O_RSTW);
    drive(0, 0, 0, 0, 0, 1, 0, 1'b0);  cycle("mr_rst_run", O_RSTR);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);  cycle("mr_recover", O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Combines load-use hazard detection (ID vs. EX), branch-taken flush of IF/ID, and a blocking request/acknowledge handshake with the data cache for MEM-stage loads and stores. Drives the PC, IF/ID, ID/EX and global pipeline-freeze enables. Keeps a saturating stall-cycle counter and a sticky cache-timeout error.

## Interface
Parameters:
- TIMEOUT, 255: maximum consecutive MEM_WAIT cycles without `cache_ack_i` before entering ERROR; legal range 1..255.
- CNT_W, 32: width of `stall_cnt_o`.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- IF_ID_Rs1_i  in  5  rs1 of the instruction in ID.
- IF_ID_Rs2_i  in  5  rs2 of the instruction in ID.
- ID_EX_Rd_i  in  5  rd of the instruction in EX.
- ID_EX_MemRead_i  in  1  the EX instruction is a load.
- Branch_i  in  1  branch resolved taken in ID this cycle.
- MemReq_i  in  1  the MEM-stage instruction accesses the data cache.
- cache_ack_i  in  1  cache has completed the current access.
- cache_req_o  out  1  access request to the cache.
- PCWrite_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF/ID register enable.
- NoOp_o  out  1  inserts a bubble into ID/EX (zeroes its control fields).
- Flush_o  out  1  clears IF/ID.
- Stall_o  out  1  global freeze of PC and all pipeline registers.
- error_o  out  1  sticky cache-timeout flag.
- state_o  out  2  current FSM state, for debug.
- stall_cnt_o  out  CNT_W  saturating count of stall/bubble cycles.

## Operation
- FSM states: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10. Encoding 2'b11 is illegal and returns to RUN on the next edge.
- RUN:
  - `cache_req_o = MemReq_i`.
  - If `MemReq_i && !cache_ack_i`: `Stall_o=1`, next state MEM_WAIT, wait counter loads 1.
  - If `MemReq_i && cache_ack_i` (hit in the same cycle): no stall, remain in RUN.
- MEM_WAIT:
  - `cache_req_o=1` and `Stall_o=1` every cycle until `cache_ack_i`.
  - Ack cycle: `Stall_o=0`, next state RUN.
  - No ack and wait counter == TIMEOUT: next state ERROR.
  - Otherwise the wait counter increments.
- ERROR:
  - `Stall_o=1`, `cache_req_o=0`, `error_o=1`.
  - Only reset leaves ERROR.
- Load-use hazard: `ID_EX_MemRead_i && ID_EX_Rd_i!=0 && (ID_EX_Rd_i==IF_ID_Rs1_i || ID_EX_Rd_i==IF_ID_Rs2_i)`.
- Priority:
  - `Stall_o` overrides everything: `PCWrite_o=0`, `IF_ID_Write_o=0`, `NoOp_o=0`, `Flush_o=0`.
  - Otherwise, on a load-use hazard: `PCWrite_o=0`, `IF_ID_Write_o=0`, `NoOp_o=1`, `Flush_o=0`. A branch is suppressed and re-resolves next cycle.
  - Otherwise `Branch_i` gives `Flush_o=1`, with PC and IF/ID writes enabled.
  - Otherwise: `PCWrite_o=1`, `IF_ID_Write_o=1`, others 0.
- `stall_cnt_o` increments by 1 in each cycle where `Stall_o|NoOp_o`. It saturates at all-ones.

## Timing
- Hazard and flush outputs are combinational from inputs and current state: zero latency.
- `Stall_o` and `cache_req_o` assert in the same cycle as `MemReq_i` (miss). `Stall_o` drops in the same cycle as `cache_ack_i`.
- A miss acked k cycles after the request yields k stall cycles.
- `cache_ack_i` in RUN with `MemReq_i=0` is ignored.
- Reset (`rst_i=0` at an edge):
  - state←RUN, wait counter←0, `stall_cnt_o`←0, `error_o`←0.
  - Reset takes effect at the edge regardless of state, including mid-MEM_WAIT.
  - While `rst_i=0`, `cache_req_o` is forced 0.
- Post-reset outputs with idle inputs: `PCWrite_o=1`, `IF_ID_Write_o=1`, all others 0, `state_o=00`.
- TIMEOUT=1: the first no-ack cycle in MEM_WAIT moves to ERROR.

## Structure
- Shared package holds:
  - state localparams ST_RUN, ST_WAIT, ST_ERR;
  - register-index width (5);
  - the wait-counter width, derived from TIMEOUT.
- One sub-module, `load_use_detect`: purely combinational comparator producing the hazard bit.
- The FSM, wait counter, stall counter and output priority mux live in the top module.

## Test plan
- Reset then idle: 3 cycles. Outputs `PCWrite_o=1`, `IF_ID_Write_o=1`, rest 0, `stall_cnt_o=0`.
- Load-use, `ID_EX_MemRead_i=1`, Rd=5, Rs2=5, one cycle: `NoOp_o=1`, `PCWrite_o=0`, `stall_cnt_o`→1. Same setup with Rd=0: no hazard.
- `MemReq_i=1`, ack 3 cycles later: `Stall_o=1` for 3 cycles, `cache_req_o=1` for 4 cycles, state 01→00, `stall_cnt_o`+3. Same-cycle ack: no stall.
- Branch together with load-use: `NoOp_o=1`, `Flush_o=0`. Next cycle, hazard cleared and branch still asserted: `Flush_o=1`.
- TIMEOUT=4, no ack: ERROR after 4 wait cycles, `error_o=1`, `cache_req_o=0`, `Stall_o` held high; `rst_i` low for one edge recovers to RUN.
- Reset asserted mid-MEM_WAIT: state returns to RUN at that edge, and `cache_req_o=0` while reset is low.
